reg_xfer_seq: RTL and testbench

//   Upstream control stage for the reg16 register bank. Accepts register-transfer requests
//   (up to three sources, one destination) through a valid/ready handshake and queues them.
//   Per request it drives the one-hot tri-state output enables for buses A/B/C, then the
//   one-hot write enable. Two-stage pipeline (EXEC, WB) sustains one transfer per cycle.

---
 rtl/cpu_regs_pkg.sv | 24 ++
 rtl/reg_xfer_seq_if.sv | 22 ++
 rtl/reg_xfer_fifo.sv | 36 +++
 rtl/reg_xfer_seq.sv | 73 +++++++
 tb/tb_reg_xfer_seq.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_regs_pkg.sv
// cpu_regs_pkg: shared sizes, request word layout and one-hot decode for reg_xfer_seq
//   NREGS_DEF/AW_DEF : default bank size and register index width
//   MAXN/MAXAW       : widest bank/index the onehot helper supports
//   field_e/field_off: bit offsets of each field inside a packed request word
//   req_w            : packed request word width for a given index width
//   onehot           : index -> one-hot mask, all zero when index >= n
package cpu_regs_pkg;
   localparam int NREGS_DEF = 8;
   localparam int AW_DEF = 3;
   localparam int MAXN = 32;
   localparam int MAXAW = 5;
   typedef enum int {F_SRCA, F_SRCB, F_SRCC, F_CEN, F_DST, F_WB} field_e;
   function automatic int req_w(input int aw);
      return 4 * aw + 2;
   endfunction
   // Layout LSB first: srca, srcb, srcc, c_en, dst, wb
   function automatic int field_off(input field_e f, input int aw);
      return (f <= F_CEN) ? aw * int'(f) : aw * (int'(f) - 1) + 1;
   endfunction
   function automatic logic [MAXN-1:0] onehot(input logic [MAXAW-1:0] idx, input int n);
      onehot = '0;
      if (int'(idx) < n) onehot[idx] = 1'b1;
   endfunction
endpackage

// File: rtl/reg_xfer_seq_if.sv
// reg_xfer_seq_if: request handshake and register-bank enable bundle for reg_xfer_seq
//   req_valid/req_ready           : request handshake
//   req_srca/srcb/srcc/c_en/dst/wb: request fields
//   oe_a/oe_b/oe_c/we             : one-hot bus output enables and write enable
//   done/busy                     : WB pulse and activity flag
//   master drives requests; slave (the sequencer) drives the enables
interface reg_xfer_seq_if #(
   parameter int NREGS = 8,
   parameter int AW = 3
);
   logic req_valid, req_ready, req_c_en, req_wb, done, busy;
   logic [AW-1:0] req_srca, req_srcb, req_srcc, req_dst;
   logic [NREGS-1:0] oe_a, oe_b, oe_c, we;
   modport master (
      output req_valid, req_srca, req_srcb, req_srcc, req_c_en, req_dst, req_wb,
      input req_ready, oe_a, oe_b, oe_c, we, done, busy
   );
   modport slave (
      input req_valid, req_srca, req_srcb, req_srcc, req_c_en, req_dst, req_wb,
      output req_ready, oe_a, oe_b, oe_c, we, done, busy
   );
endinterface

// File: rtl/reg_xfer_fifo.sv
// reg_xfer_fifo: show-ahead synchronous FIFO with extra-bit pointers
//   clk, reset (async active-low)
//   wr_en/wr_data : push, ignored when full
//   rd_en/rd_data : pop, rd_data shows the head combinationally
//   full/empty    : status
module reg_xfer_fifo #(
   parameter int W = 8,
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic reset,
   input logic wr_en,
   input logic [W-1:0] wr_data,
   input logic rd_en,
   output logic [W-1:0] rd_data,
   output logic full,
   output logic empty
);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [PW:0] wp, rp;
   assign empty = wp == rp;
   assign full = (wp ^ rp) == {1'b1, {PW{1'b0}}};
   assign rd_data = mem[rp[PW-1:0]];
   always_ff @(posedge clk)
      if (wr_en && !full) mem[wp[PW-1:0]] <= wr_data;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr_en && !full) wp <= wp + 1'b1;
         if (rd_en && !empty) rp <= rp + 1'b1;
      end
   end
endmodule

// File: rtl/reg_xfer_seq.sv
// reg_xfer_seq: queued register-transfer sequencer driving reg16 bus and write enables
//   clk, reset (async active-low)
//   bus.slave : req_* handshake/fields in; oe_a/oe_b/oe_c/we one-hot enables,
//               done (WB pulse), busy, req_ready out
//   REGSEQ_HAZARD_EN: hold the queue head one cycle when it reads the register
//               that EXEC is about to write; undefined = no interlock
module reg_xfer_seq
   import cpu_regs_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int AW = AW_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input logic clk,
   input logic reset,
   reg_xfer_seq_if.slave bus
);
   localparam int RW = req_w(AW);
   localparam int O_A = field_off(F_SRCA, AW);
   localparam int O_B = field_off(F_SRCB, AW);
   localparam int O_C = field_off(F_SRCC, AW);
   localparam int O_CE = field_off(F_CEN, AW);
   localparam int O_D = field_off(F_DST, AW);
   localparam int O_WB = field_off(F_WB, AW);
   logic [RW-1:0] head;
   logic full, empty, pop, ex_v;
   logic [NREGS-1:0] ha, hb, hc, hw, ex_we;
   assign bus.req_ready = !full;
   assign bus.busy = !empty || ex_v || bus.done;
   reg_xfer_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .wr_en(bus.req_valid && !full),
      .wr_data({bus.req_wb, bus.req_dst, bus.req_c_en, bus.req_srcc, bus.req_srcb, bus.req_srca}),
      .rd_en(pop),
      .rd_data(head),
      .full(full),
      .empty(empty)
   );
   // Head decoded straight to enable masks; out-of-range indices decode to zero
   always_comb begin
      ha = NREGS'(onehot(MAXAW'(head[O_A +: AW]), NREGS));
      hb = NREGS'(onehot(MAXAW'(head[O_B +: AW]), NREGS));
      hc = head[O_CE] ? NREGS'(onehot(MAXAW'(head[O_C +: AW]), NREGS)) : '0;
      hw = head[O_WB] ? NREGS'(onehot(MAXAW'(head[O_D +: AW]), NREGS)) : '0;
`ifdef REGSEQ_HAZARD_EN
      // ex_we is nonzero only for a valid EXEC that will really write
      pop = !empty && (ex_we & (ha | hb | hc)) == '0;
`else
      pop = !empty;
`endif
   end
   // WB always follows EXEC, so EXEC is free every cycle and ex_we doubles as the WB payload
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_v <= 1'b0;
         ex_we <= '0;
         bus.oe_a <= '0;
         bus.oe_b <= '0;
         bus.oe_c <= '0;
         bus.we <= '0;
         bus.done <= 1'b0;
      end else begin
         ex_v <= pop;
         ex_we <= pop ? hw : '0;
         bus.oe_a <= pop ? ha : '0;
         bus.oe_b <= pop ? hb : '0;
         bus.oe_c <= pop ? hc : '0;
         bus.we <= ex_we;
         bus.done <= ex_v;
      end
   end
endmodule

// File: tb/tb_reg_xfer_seq.sv
// tb_reg_xfer_seq: directed and randomized checks of reg_xfer_seq against a transaction model
module tb_reg_xfer_seq;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;
   typedef struct {
      logic [2:0] a, b, c, d;
      bit ce, wb;
   } req_t;
   always #5 clk = ~clk;
   reg_xfer_seq_if #(.NREGS(8), .AW(3)) b8 ();
   reg_xfer_seq_if #(.NREGS(6), .AW(3)) b6 ();
   reg_xfer_seq #(.NREGS(8), .AW(3), .FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(b8));
   reg_xfer_seq #(.NREGS(6), .AW(3), .FIFO_DEPTH(4)) dut6 (.clk(clk), .reset(reset), .bus(b6));
   function automatic logic [7:0] oh(input int idx, input int n);
      return (idx < n) ? 8'(1) << idx : 8'h00;
   endfunction
   function automatic logic [23:0] exec_oh(input req_t r, input int n);
      return {oh(int'(r.a), n), oh(int'(r.b), n), r.ce ? oh(int'(r.c), n) : 8'h00};
   endfunction
   function automatic logic [7:0] wb_oh(input req_t r, input int n);
      return r.wb ? oh(int'(r.d), n) : 8'h00;
   endfunction
   function automatic req_t mk(input int a, input int b, input int c, input bit ce, input int d, input bit wb);
      req_t r;
      r.a = 3'(a);
      r.b = 3'(b);
      r.c = 3'(c);
      r.ce = ce;
      r.d = 3'(d);
      r.wb = wb;
      return r;
   endfunction
   task automatic drive8(input req_t r, input bit v);
      b8.req_valid = v;
      b8.req_srca = r.a;
      b8.req_srcb = r.b;
      b8.req_srcc = r.c;
      b8.req_c_en = r.ce;
      b8.req_dst = r.d;
      b8.req_wb = r.wb;
   endtask
   task automatic drive6(input req_t r, input bit v);
      b6.req_valid = v;
      b6.req_srca = r.a;
      b6.req_srcb = r.b;
      b6.req_srcc = r.c;
      b6.req_c_en = r.ce;
      b6.req_dst = r.d;
      b6.req_wb = r.wb;
   endtask
   task automatic test_reset;
      drive8(mk(1, 2, 3, 1, 4, 1), 1'b1);
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if ({b8.oe_a, b8.oe_b, b8.oe_c, b8.we, b8.done, b8.busy} !== 34'h0)
            begin errors++; $display("FAIL reset_hold got %h exp 0", {b8.oe_a, b8.oe_b, b8.oe_c, b8.we, b8.done, b8.busy}); end
      end
      b8.req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({b8.req_ready, b8.busy, b8.done} !== 3'b100)
         begin errors++; $display("FAIL reset_release got %b exp 100", {b8.req_ready, b8.busy, b8.done}); end
   endtask
   task automatic test_single;
      logic [33:0] exp_s [4];
      exp_s[0] = {8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
      exp_s[1] = {8'h02, 8'h04, 8'h00, 8'h00, 1'b0, 1'b1};
      exp_s[2] = {8'h00, 8'h00, 8'h00, 8'h08, 1'b1, 1'b1};
      exp_s[3] = 34'h0;
      drive8(mk(1, 2, 6, 0, 3, 1), 1'b1);
      for (int j = 0; j < 4; j++) begin
         @(posedge clk); #1;
         b8.req_valid = 1'b0;
         checks++;
         if ({b8.oe_a, b8.oe_b, b8.oe_c, b8.we, b8.done, b8.busy} !== exp_s[j])
            begin errors++; $display("FAIL single[%0d] got %h exp %h", j, {b8.oe_a, b8.oe_b, b8.oe_c, b8.we, b8.done, b8.busy}, exp_s[j]); end
      end
   endtask
   task automatic test_back_to_back;
      req_t s [6];
      logic [23:0] eo;
      logic [7:0] ew;
      bit ed;
      for (int k = 0; k < 6; k++) s[k] = mk(k, (k + 1) % 8, 7 - k, k % 2 == 1, (k + 4) % 8, k != 3);
      for (int j = 0; j < 9; j++) begin
         if (j < 6) drive8(s[j], 1'b1);
         else b8.req_valid = 1'b0;
         @(posedge clk); #1;
         eo = '0;
         ew = '0;
         ed = 1'b0;
         if (j >= 1 && j <= 6) eo = exec_oh(s[j-1], 8);
         if (j >= 2 && j <= 7) begin ew = wb_oh(s[j-2], 8); ed = 1'b1; end
         checks++;
         if ({b8.oe_a, b8.oe_b, b8.oe_c, b8.we, b8.done, b8.req_ready} !== {eo, ew, ed, 1'b1})
            begin errors++; $display("FAIL stream[%0d] got %h exp %h", j, {b8.oe_a, b8.oe_b, b8.oe_c, b8.we, b8.done, b8.req_ready}, {eo, ew, ed, 1'b1}); end
      end
   endtask
   task automatic test_hazard;
      logic [32:0] exp_h [5];
      exp_h[0] = 33'h0;
      exp_h[1] = {8'h01, 8'h02, 8'h00, 8'h00, 1'b0};
`ifdef REGSEQ_HAZARD_EN
      exp_h[2] = {8'h00, 8'h00, 8'h00, 8'h20, 1'b1};
      exp_h[3] = {8'h20, 8'h04, 8'h00, 8'h00, 1'b0};
      exp_h[4] = {8'h00, 8'h00, 8'h00, 8'h40, 1'b1};
`else
      exp_h[2] = {8'h20, 8'h04, 8'h00, 8'h20, 1'b1};
      exp_h[3] = {8'h00, 8'h00, 8'h00, 8'h40, 1'b1};
      exp_h[4] = 33'h0;
`endif
      for (int j = 0; j < 5; j++) begin
         if (j == 0) drive8(mk(0, 1, 0, 0, 5, 1), 1'b1);
         else if (j == 1) drive8(mk(5, 2, 0, 0, 6, 1), 1'b1);
         else b8.req_valid = 1'b0;
         @(posedge clk); #1;
         checks++;
         if ({b8.oe_a, b8.oe_b, b8.oe_c, b8.we, b8.done} !== exp_h[j])
            begin errors++; $display("FAIL hazard[%0d] got %h exp %h", j, {b8.oe_a, b8.oe_b, b8.oe_c, b8.we, b8.done}, exp_h[j]); end
      end
      repeat (2) @(posedge clk);
      #1;
   endtask
   task automatic test_out_of_range;
      logic [25:0] exp_r [5];
      exp_r[0] = {6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 1'b1};
      exp_r[1] = {6'h00, 6'h04, 6'h00, 6'h00, 1'b0, 1'b1};
      exp_r[2] = {6'h01, 6'h20, 6'h08, 6'h02, 1'b1, 1'b1};
      exp_r[3] = {6'h00, 6'h00, 6'h00, 6'h00, 1'b1, 1'b1};
      exp_r[4] = 26'h0;
      for (int j = 0; j < 5; j++) begin
         if (j == 0) drive6(mk(7, 2, 6, 1, 1, 1), 1'b1);
         else if (j == 1) drive6(mk(0, 5, 3, 1, 7, 1), 1'b1);
         else b6.req_valid = 1'b0;
         @(posedge clk); #1;
         checks++;
         if ({b6.oe_a, b6.oe_b, b6.oe_c, b6.we, b6.done, b6.busy} !== exp_r[j])
            begin errors++; $display("FAIL range[%0d] got %h exp %h", j, {b6.oe_a, b6.oe_b, b6.oe_c, b6.we, b6.done, b6.busy}, exp_r[j]); end
      end
   endtask
`ifdef REGSEQ_HAZARD_EN
   task automatic test_full;
      int nacc = 0;
      int ndone = 0;
      bit acc;
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         drive8(mk(1, 1, 0, 0, 1, 1), 1'b1);
         acc = b8.req_ready;
         @(posedge clk); #1;
         if (acc) nacc++;
         if (b8.done) ndone++;
         if (!b8.req_ready) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL full_ready got 1 exp 0 within 20 cycles"); end
      b8.req_valid = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (b8.done) ndone++;
      end
      checks++;
      if (ndone != nacc) begin errors++; $display("FAIL full_drain got %0d done exp %0d", ndone, nacc); end
   endtask
`endif
   task automatic test_random;
      req_t q [$];
      req_t r, e;
      logic [23:0] prev_oe = '0;
      bit acc;
      int nacc = 0;
      int ndone = 0;
      for (int i = 0; i < 420; i++) begin
         r = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                1'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
         drive8(r, i < 380 && $urandom_range(0, 3) != 0);
         acc = b8.req_valid && b8.req_ready;
         @(posedge clk); #1;
         if (acc) begin q.push_back(r); nacc++; end
         checks++;
         if (b8.done) begin
            ndone++;
            if (q.size() == 0) begin errors++; $display("FAIL rand[%0d] done with empty model queue", i); end
            else begin
               e = q.pop_front();
               if ({prev_oe, b8.we} !== {exec_oh(e, 8), wb_oh(e, 8)})
                  begin errors++; $display("FAIL rand[%0d] got %h exp %h", i, {prev_oe, b8.we}, {exec_oh(e, 8), wb_oh(e, 8)}); end
            end
         end else if ({prev_oe, b8.we} !== 32'h0)
            begin errors++; $display("FAIL rand_idle[%0d] got %h exp 0", i, {prev_oe, b8.we}); end
         prev_oe = {b8.oe_a, b8.oe_b, b8.oe_c};
      end
      checks++;
      if (q.size() != 0 || b8.busy !== 1'b0 || ndone != nacc)
         begin errors++; $display("FAIL rand_drain got left %0d busy %b done %0d exp left 0 busy 0 done %0d", q.size(), b8.busy, ndone, nacc); end
   endtask
   task automatic test_async_reset;
      req_t s [4];
      for (int k = 0; k < 4; k++) s[k] = mk(k, k, 0, 0, k + 4, 1);
      for (int k = 0; k < 3; k++) begin
         drive8(s[k], 1'b1);
         @(posedge clk); #1;
      end
      checks++;
      if ({b8.we, b8.done} !== {wb_oh(s[0], 8), 1'b1})
         begin errors++; $display("FAIL areset_pre got %h exp %h", {b8.we, b8.done}, {wb_oh(s[0], 8), 1'b1}); end
      drive8(s[3], 1'b1);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({b8.oe_a, b8.oe_b, b8.oe_c, b8.we, b8.done, b8.busy} !== 34'h0)
         begin errors++; $display("FAIL areset_now got %h exp 0", {b8.oe_a, b8.oe_b, b8.oe_c, b8.we, b8.done, b8.busy}); end
      b8.req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(posedge clk); #1;
         checks++;
         if ({b8.we, b8.done, b8.busy} !== 10'h0)
            begin errors++; $display("FAIL areset_after[%0d] got %h exp 0", j, {b8.we, b8.done, b8.busy}); end
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      drive8(mk(0, 0, 0, 0, 0, 0), 1'b0);
      drive6(mk(0, 0, 0, 0, 0, 0), 1'b0);
      test_reset;
      test_single;
      test_back_to_back;
      test_hazard;
      test_out_of_range;
`ifdef REGSEQ_HAZARD_EN
      test_full;
`endif
      test_random;
      test_async_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
